// File: rtl/packet_unpacker.sv
// ============================================================================
// Module      : packet_unpacker
// Description : Buffers one header+data packet and streams its data words
//               lowest-first over a valid/ready output, reloading on the
//               last word so consecutive packets stream without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_unpacker #(
  parameter int DWIDTH = 8,
  parameter int NWORDS = 5,
  parameter int PWIDTH = 47,
  parameter int CWIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PWIDTH-1:0]                   in_packet,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DWIDTH-1:0]                   out_data,
  output logic [PWIDTH-NWORDS*DWIDTH-1:0]     out_hdr,
  output logic [$clog2(NWORDS)-1:0]           out_idx,
  output logic                                out_last,
  output logic [CWIDTH-1:0]                   pkt_count
);

  localparam int HWIDTH = PWIDTH - NWORDS * DWIDTH;
  localparam int IWIDTH = $clog2(NWORDS);
  localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(NWORDS - 1);

  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IWIDTH-1:0]   idx_q, idx_d;
  logic [PWIDTH-1:0]   buf_q, buf_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;

  logic                w_last;
  logic [DWIDTH-1:0]   w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // idx is cleared whenever the buffer empties, so out_last is low in EMPTY
  assign w_last = (idx_q == LAST_IDX);

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx_q == IWIDTH'(k)) begin
        w_word = buf_q[k*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_packet;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        in_ready = out_ready && w_last;
        if (out_ready) begin
          if (!w_last) begin
            idx_d = idx_q + IWIDTH'(1);
          end else begin
            cnt_d = cnt_q + CWIDTH'(1);
            idx_d = '0;
            // Same-cycle reload keeps the output busy across packet borders
            if (in_valid) begin
              buf_d = in_packet;
            end else begin
              state_d = EMPTY;
            end
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign out_valid = (state_q == STREAM);
  assign out_data  = w_word;
  assign out_hdr   = buf_q[PWIDTH-1 -: HWIDTH];
  assign out_idx   = idx_q;
  assign out_last  = w_last;
  assign pkt_count = cnt_q;

endmodule

`default_nettype wire

// File: doc/packet_unpacker.md
# packet_unpacker

Clocked consumer stage that accepts one PWIDTH-bit packet (header plus NWORDS data words of DWIDTH bits each) over a valid/ready handshake. It emits the data words one per accepted output transfer, lowest word first, each tagged with the packet header, word index and a last flag. It sits directly downstream of the packet generator/producer and feeds word-serial consumers such as per-byte processing elements. A single packet buffer plus same-cycle reload gives back-to-back streaming with no bubble between packets.

## Interface
- DWIDTH, 8, width of one data word
- NWORDS, 5, data words per packet
- PWIDTH, 47, total packet width; header width HWIDTH = PWIDTH - NWORDS*DWIDTH (7 by default); PWIDTH must exceed NWORDS*DWIDTH
- CWIDTH, 16, width of the completed-packet counter

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer presents a packet
- in_ready  out  1  unpacker accepts the packet this cycle
- in_packet  in  PWIDTH  layout {header[HWIDTH-1:0], word[NWORDS-1], ..., word[0]}; word k = bits [k*DWIDTH +: DWIDTH]
- out_valid  out  1  a word is presented
- out_ready  in  1  consumer accepts the word this cycle
- out_data  out  DWIDTH  current data word
- out_hdr  out  HWIDTH  header of the packet being streamed
- out_idx  out  $clog2(NWORDS)  index of current word, 0..NWORDS-1
- out_last  out  1  high when out_idx == NWORDS-1
- pkt_count  out  CWIDTH  number of packets fully streamed out

## Operation
- States: EMPTY (no buffered packet), STREAM (buffer holds a packet; idx selects the current word).
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- in_ready = (state==EMPTY) || (state==STREAM && out_ready && out_last). This is combinational from out_ready and is the only input-to-output combinational path.
- EMPTY: out_valid=0. On an input transfer: capture in_packet into the buffer, set idx=0, go to STREAM.
- STREAM: out_valid=1; out_data = buffer word[idx]; out_hdr = buffer header; out_last = (idx==NWORDS-1).
  - Output transfer with idx<NWORDS-1: idx increments.
  - Output transfer with idx==NWORDS-1 and an input transfer in the same cycle: capture the new packet, set idx=0, stay in STREAM, pkt_count++.
  - Output transfer with idx==NWORDS-1 and no input: go to EMPTY, pkt_count++.
  - No output transfer: hold all state; out_data, out_hdr, out_idx and out_last stay stable while out_valid=1.
- in_packet is ignored whenever in_ready=0. The producer must hold the packet until in_ready.
- pkt_count increments by 1 per last-word transfer and wraps from 2^CWIDTH-1 to 0.
- Header bits are passed through uninterpreted.

## Timing
- Reset (rst_n low, asynchronous): state=EMPTY, idx=0, buffer=0, pkt_count=0. Outputs: out_valid=0, out_data=0, out_hdr=0, out_idx=0, out_last=0, in_ready=1 after reset. Deassertion is sampled on the next rising edge.
- Reset asserted mid-packet: the buffered packet is discarded and its remaining words are never emitted. pkt_count clears.
- Latency: a packet accepted at edge N gives out_valid=1 with word 0 during the cycle after edge N.
- Throughput: with out_ready held high and in_valid held high, exactly one word per cycle. The next packet's word 0 follows the previous packet's last word with zero idle cycles. The sustained rate is one packet per NWORDS cycles.
- Output backpressure: out_ready low stalls indefinitely with no loss. in_ready stays 0 until the last-word transfer.
- out_valid never drops in STREAM until the last word transfers.

## Test plan
- Single packet: in_packet = {7'h2A, 40'h5544332211}, out_ready=1 → words 0x11,0x22,0x33,0x44,0x55 on consecutive cycles, out_hdr=0x2A throughout, out_idx 0..4, out_last only on 0x55, then out_valid=0 and pkt_count=1.
- Back-to-back: two packets presented continuously, the second being {7'h01, 40'hEEDDCCBBAA} → 10 consecutive out_valid cycles, 0xAA directly follows 0x55 with out_hdr=0x01. in_ready pulses high exactly in the cycle of the first packet's last-word transfer. pkt_count=2.
- Backpressure: out_ready toggled 1,0,0,1,0,1,1,1 during one packet → each word held stable while stalled, no word duplicated or dropped, in_ready=0 until the last transfer.
- Reset mid-stream: assert rst_n=0 asynchronously after word 0x22 transfers → out_valid=0 and pkt_count=0 immediately, without waiting for a clock edge. After release, a new packet {7'h7F, 40'h0102030405} streams 0x05 first.
- Counter wrap, using CWIDTH=4 override: 17 packets streamed → pkt_count reads 15 after packet 15, then 0, then 1.
- Idle input: in_valid=0 for 20 cycles after reset → out_valid=0, in_ready=1 and pkt_count=0 throughout.
